// File: rtl/serial_pkg_311.sv
// serial_pkg_311: shared FSM state type and frame-length helper for the serial link
package serial_pkg_311;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  function automatic int frame_cycles(int data_w, int clks_per_bit, int parity_en);
    return (2 + data_w + parity_en) * clks_per_bit;
  endfunction
endpackage

// File: rtl/baud_tick_311.sv
// baud_tick_311: bit-period counter that pulses in the last cycle of each bit
module baud_tick_311 #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_311,
  input  logic clr_311,
  output logic tick_311
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // tick on the terminal count; wrap on tick, restart on clear
  always_comb begin
    tick_311 = cnt_q == CW'(CLKS_PER_BIT - 1);
    cnt_d = (clr_311 || tick_311) ? '0 : cnt_q + 1'b1;
  end
  // counter register
  always_ff @(posedge clk or posedge reset_311)
    if (reset_311) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/serial_tx_311.sv
// serial_tx_311: LSB-first start/data/parity/stop frame transmitter with true/complement line
module serial_tx_311 import serial_pkg_311::*; #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              reset_311,
  input  logic [DATA_W-1:0] data_311,
  input  logic              valid_311,
  output logic              ready_311,
  output logic              busy_311,
  output logic              tx_311,
  output logic              txb_311
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  tx_state_t state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic par_q, par_d, tx_q, tx_d, txb_q, txb_d, tick, clr, last;
  baud_tick_311 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .reset_311 (reset_311),
    .clr_311   (clr),
    .tick_311  (tick)
  );
  // next-state, shift/count updates, and the line value for the state being entered
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bit_d = bit_q;
    par_d = par_q;
    last = bit_q == BW'(DATA_W - 1);
    case (state_q)
      IDLE: if (valid_311) begin
        state_d = START;
        sh_d = data_311;
        par_d = ^data_311;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        sh_d = sh_q >> 1;
        bit_d = last ? '0 : bit_q + 1'b1;
        if (last) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (tick) state_d = STOP;
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    clr = (state_d != state_q) || (state_q == IDLE);
    tx_d = state_d == START ? 1'b0 :
           state_d == DATA ? sh_d[0] :
           state_d == PARITY ? par_d : 1'b1;
    txb_d = ~tx_d;
  end
  // state, datapath and output registers; reset parks the line at mark
  always_ff @(posedge clk or posedge reset_311)
    if (reset_311) begin
      state_q <= IDLE;
      sh_q <= '0;
      bit_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      txb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      par_q <= par_d;
      tx_q <= tx_d;
      txb_q <= txb_d;
    end
  assign ready_311 = state_q == IDLE;
  assign busy_311 = !ready_311;
  assign tx_311 = tx_q;
  assign txb_311 = txb_q;
endmodule

// File: tb/tb_serial_tx_311.sv
// tb_serial_tx_311: directed frame checks for the default and a narrow 1-clock-per-bit configuration
module tb_serial_tx_311;
  logic clk = 0, rst = 0;
  logic [7:0] data = 0;
  logic valid = 0;
  logic ready, busy, tx, txb;
  logic [4:0] data5 = 0;
  logic valid5 = 0;
  logic ready5, busy5, tx5, txb5;
  int checks = 0, errors = 0;
  typedef struct {logic [7:0] d; logic p;} vec_t;
  vec_t tbl[6];

  serial_tx_311 dut (
    .clk(clk), .reset_311(rst), .data_311(data), .valid_311(valid),
    .ready_311(ready), .busy_311(busy), .tx_311(tx), .txb_311(txb)
  );
  serial_tx_311 #(.DATA_W(5), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut5 (
    .clk(clk), .reset_311(rst), .data_311(data5), .valid_311(valid5),
    .ready_311(ready5), .busy_311(busy5), .tx_311(tx5), .txb_311(txb5)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " tx"}, tx, 1);
    chk({nm, " txb"}, txb, 0);
    chk({nm, " ready"}, ready, 1);
    chk({nm, " busy"}, busy, 0);
  endtask

  // called at a negedge with the DUT idle; offers d, then checks the whole 44-cycle frame
  task automatic run_frame(input logic [7:0] d, input logic p, input logic hold, input logic [7:0] nxt);
    logic [10:0] fr;
    fr = {1'b1, p, d, 1'b0};
    chk($sformatf("ready_pre d%0h", d), ready, 1);
    data = d;
    valid = 1;
    @(posedge clk);
    #1;
    data = nxt;
    valid = hold;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      chk($sformatf("tx d%0h c%0d", d, c), tx, fr[c/4]);
      chk($sformatf("txb d%0h c%0d", d, c), txb, !fr[c/4]);
      chk($sformatf("busy d%0h c%0d", d, c), busy, 1);
    end
    @(negedge clk);
    chk($sformatf("ready_post d%0h", d), ready, 1);
    chk($sformatf("mark d%0h", d), tx, 1);
  endtask

  initial begin
    logic [6:0] exp5;
    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h01, 1'b1};
    tbl[2] = '{8'hFF, 1'b0};
    tbl[3] = '{8'h13, 1'b1};
    tbl[4] = '{8'h7E, 1'b0};
    tbl[5] = '{8'h00, 1'b0};
    #1 rst = 1;
    #1 chk_idle("reset_init");
    @(negedge clk) rst = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_frame(tbl[i].d, tbl[i].p, 0, 8'h00);
    run_frame(8'h3C, 0, 1, 8'h99);
    run_frame(8'h99, 0, 0, 8'h00);
    run_frame(8'h01, 1, 1, 8'hFF);
    run_frame(8'hFF, 0, 0, 8'h00);
    data = 8'hA5;
    valid = 1;
    @(posedge clk);
    #1 valid = 0;
    @(negedge clk);
    chk("start_before_reset", tx, 0);
    #2 rst = 1;
    #1 chk_idle("reset_async_start");
    @(negedge clk) rst = 0;
    @(negedge clk);
    chk_idle("no_resume_start");
    data = 8'h0F;
    valid = 1;
    @(posedge clk);
    #1 valid = 0;
    repeat (18) @(negedge clk);
    chk("busy_bit3", busy, 1);
    #2 rst = 1;
    #1 chk_idle("reset_async_bit3");
    @(negedge clk) rst = 0;
    run_frame(8'h80, 1, 0, 8'h00);
    exp5 = 7'b1101100;
    chk("ready5_pre", ready5, 1);
    data5 = 5'b10110;
    valid5 = 1;
    @(posedge clk);
    #1 valid5 = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("tx5 c%0d", c), tx5, exp5[c]);
      chk($sformatf("txb5 c%0d", c), txb5, !exp5[c]);
      chk($sformatf("busy5 c%0d", c), busy5, 1);
    end
    @(negedge clk);
    chk("ready5_post", ready5, 1);
    chk("tx5_mark", tx5, 1);
    chk("txb5_mark", txb5, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_tx_311.md
# serial_tx_311

Parameterised serial-frame transmitter that serialises a parallel word onto a single line, LSB-first. Each frame is a start bit, the data bits, an optional even-parity bit and a stop bit. It is the transmit end of the flip-flop/shift-register serial link in the digital-logic library. Words arrive from a producer over a valid/ready handshake. The line is driven as a registered true/complement pair, in the same style as the library's flip-flops.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 4, clock cycles per serial bit (≥1)
- PARITY_EN, 1, 1 = insert even-parity bit after data, 0 = no parity bit

Ports:
- clk  input  1  single clock, all state updates on posedge
- reset_311  input  1  asynchronous, active-high reset
- data_311  input  DATA_W  word to send, sampled on accepted handshake only
- valid_311  input  1  producer has a word on data_311
- ready_311  output  1  block can accept a word this cycle
- busy_311  output  1  frame in progress
- tx_311  output  1  serial line, idle/mark = 1
- txb_311  output  1  complement of tx_311 at all times

## Operation
- Reset values, applied asynchronously while reset_311 = 1:
  - state = IDLE
  - tx_311 = 1, txb_311 = 0
  - ready_311 = 1, busy_311 = 0
  - shift register, bit counter and baud counter all 0
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on valid_311 && ready_311 at a clock edge. data_311 is captured into the shift register and parity is computed at that edge.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY (PARITY_EN = 1) or STOP (PARITY_EN = 0) after DATA_W bit periods.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after one bit period.
- ready_311 = (state == IDLE). busy_311 = !ready_311. Both are decoded from the state register only, with no combinational path from valid_311.
- Line values per state:
  - START: tx_311 = 0.
  - DATA: tx_311 = shift register bit 0. The register shifts right at the end of each data bit period.
  - PARITY: tx_311 = XOR of the captured word, so ones(data) + parity is even.
  - STOP and IDLE: tx_311 = 1.
- tx_311 and txb_311 are registered outputs; txb_311 is always the complement of tx_311.
- While busy:
  - valid_311 is ignored.
  - Changes on data_311 have no effect on the frame in flight.
- Reset mid-frame: the frame is aborted and the line goes to mark immediately (asynchronous). No partial frame resumes after release.
- Bit counter width is $clog2(DATA_W) (minimum 1). It wraps to 0 on the DATA exit.
- Baud counter counts 0..CLKS_PER_BIT-1 and clears on every state change. With CLKS_PER_BIT = 1 each bit lasts exactly one cycle.

## Timing
- Handshake accepted at edge T:
  - Start bit appears on tx_311 after edge T (tx_311 low during cycle T+1).
  - Latency from handshake to start bit is 1 cycle.
- Frame length: F = (2 + DATA_W + PARITY_EN) × CLKS_PER_BIT cycles, occupying cycles T+1 … T+F.
- ready_311 = 1 again in cycle T+F+1. The earliest next accept is edge T+F+1.
- Back-to-back frames therefore have exactly one idle mark cycle between the stop bit and the next start bit.
- Handshake in the same cycle as reset deassertion: accepted only if reset_311 is already low at that edge.

## Structure
- Shared package serial_pkg_311 holds:
  - state enum type tx_state_t (IDLE, START, DATA, PARITY, STOP)
  - frame-length function frame_cycles(DATA_W, CLKS_PER_BIT, PARITY_EN), shared with the matching receiver and benches
- Sub-module baud_tick_311:
  - parameterised by CLKS_PER_BIT
  - inputs clk, reset_311 and a synchronous clear
  - outputs a one-cycle tick in the last cycle of each bit period
- Top level contains the FSM, shift register, bit counter, parity register and output registers.

## Test plan
All scenarios use defaults DATA_W = 8, CLKS_PER_BIT = 4, PARITY_EN = 1, so F = 44.
- Reset:
  - Stimulus: assert reset_311 between clock edges.
  - Required: tx_311 = 1, txb_311 = 0, ready_311 = 1, busy_311 = 0 immediately, before any edge.
- Single frame:
  - Stimulus: send 0xA5.
  - Required: tx_311 per 4-cycle bit = 0 | 1,0,1,0,0,1,0,1 | parity 0 | stop 1.
  - busy_311 is high for 44 cycles; ready_311 returns in cycle T+45.
- Valid while busy:
  - Stimulus: hold valid_311 = 1 with data_311 changing 0x3C → 0x99 during a frame.
  - Required: the current frame is unchanged. 0x99 (the value present at the edge where ready_311 = 1) is sent next, with parity 0.
- Back-to-back:
  - Stimulus: 0x01 then 0xFF, valid_311 held continuously.
  - Required: parities 1 and 0, and exactly one mark cycle between the first stop bit and the second start bit.
- Reset mid-frame:
  - Stimulus: assert reset_311 during data bit 3 of 0x0F.
  - Required: tx_311 = 1 asynchronously. After release, the next word 0x80 is sent as a clean 44-cycle frame.
- Parameter sweep:
  - Stimulus: CLKS_PER_BIT = 1, PARITY_EN = 0, DATA_W = 5, send 5'b10110.
  - Required: frame = 0,0,1,1,0,1,1 over 7 cycles, and txb_311 is the complement of tx_311 on every cycle.
